// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
//   Load/store unit between the memory stage and a handshaked, variable-latency
//   data memory. One access is in flight at a time. The request is aligned to
//   the memory word, byte-lane masks and store lanes are built at acceptance,
//   load data is extracted and sign/zero-extended, misaligned and illegal-size
//   accesses trap without touching memory, and a stalled memory is aborted
//   after TIMEOUT cycles (0 disables the abort).
//
// Ports
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_* / o_req_ready          access request from the pipeline
//   o_rsp_* / i_rsp_ready          response back to the pipeline
//   o_mem_* / i_mem_ready          memory request channel
//   i_mem_rvalid, i_mem_rdata      memory read-data return
// -----------------------------------------------------------------------------
module lsu_mem_port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_trap,
    output logic                  o_rsp_timeout,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic                  o_mem_ren,
    output logic                  o_mem_wen,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_mask,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(MASK_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 wen_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [OFF_W-1:0]     off_q;

    logic [OFF_W-1:0]     req_off_s;
    logic                 misalign_s;
    logic                 illegal_s;
    logic [15:0]          lane_base_s;
    logic [MASK_W-1:0]    mask_s;
    logic [DATA_W-1:0]    wdata_s;
    logic [DATA_W-1:0]    shifted_s;
    logic [3:0]           nbytes_s;
    logic                 fill_s;
    logic [DATA_W-1:0]    ext_s;
    logic                 timeout_hit_s;

    // Request decode: alignment check, lane mask and lane-shifted store data.
    always_comb begin
        req_off_s   = i_req_addr[OFF_W-1:0];
        lane_base_s = (16'd1 << (5'd1 << i_req_size)) - 16'd1;
        mask_s      = MASK_W'(lane_base_s) << req_off_s;
        wdata_s     = i_req_wdata << {req_off_s, 3'b000};
        illegal_s   = (i_req_size == 2'd3) && (DATA_W != 64);
        case (i_req_size)
            2'd0:    misalign_s = 1'b0;
            2'd1:    misalign_s = i_req_addr[0];
            2'd2:    misalign_s = |i_req_addr[1:0];
            default: misalign_s = |i_req_addr[2:0];
        endcase
    end

    // Load extraction: lanes above the access size are replaced by the fill bit,
    // so bytes outside the mask never reach the result.
    always_comb begin
        ext_s     = '0;
        shifted_s = i_mem_rdata >> {off_q, 3'b000};
        nbytes_s  = 4'd1 << size_q;
        case (size_q)
            2'd0:    fill_s = shifted_s[7]  & ~uns_q;
            2'd1:    fill_s = shifted_s[15] & ~uns_q;
            2'd2:    fill_s = shifted_s[31] & ~uns_q;
            default: fill_s = shifted_s[DATA_W-1] & ~uns_q;
        endcase
        for (int i = 0; i < MASK_W; i++) begin
            if (i < int'(nbytes_s)) begin
                ext_s[8*i +: 8] = shifted_s[8*i +: 8];
            end else begin
                ext_s[8*i +: 8] = {8{fill_s}};
            end
        end
        timeout_hit_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // Access state machine with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wen_q         <= 1'b0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            off_q         <= '0;
            o_req_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_trap    <= 1'b0;
            o_rsp_timeout <= 1'b0;
            o_mem_valid   <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_ren     <= 1'b0;
            o_mem_wen     <= 1'b0;
            o_mem_wdata   <= '0;
            o_mem_mask    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        wen_q       <= i_req_wen;
                        size_q      <= i_req_size;
                        uns_q       <= i_req_unsigned;
                        off_q       <= req_off_s;
                        if (misalign_s || illegal_s) begin
                            state_q     <= S_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_trap  <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            o_mem_valid <= 1'b1;
                            o_mem_ren   <= ~i_req_wen;
                            o_mem_wen   <= i_req_wen;
                            o_mem_addr  <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            o_mem_wdata <= wdata_s;
                            o_mem_mask  <= mask_s;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Timeout wins over a ready arriving in the same cycle.
                    if (timeout_hit_s || i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        o_mem_ren   <= 1'b0;
                        o_mem_wen   <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                        o_mem_mask  <= '0;
                        if (timeout_hit_s || wen_q) begin
                            state_q       <= S_RESP;
                            o_rsp_valid   <= 1'b1;
                            o_rsp_timeout <= timeout_hit_s;
                            o_rsp_rdata   <= '0;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout_hit_s) begin
                        state_q       <= S_RESP;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_timeout <= 1'b1;
                        o_rsp_rdata   <= '0;
                    end else if (i_mem_rvalid) begin
                        state_q     <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= ext_s;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        state_q       <= S_IDLE;
                        o_req_ready   <= 1'b1;
                        o_rsp_valid   <= 1'b0;
                        o_rsp_trap    <= 1'b0;
                        o_rsp_timeout <= 1'b0;
                        o_rsp_rdata   <= '0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, TIMEOUT = 8
    logic        req_valid = 1'b0, req_wen = 1'b0, req_uns = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_trap, rsp_timeout, mem_valid, mem_ren, mem_wen;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;

    // 64-bit instance, default TIMEOUT
    logic        b_req_valid = 1'b0, b_req_wen = 1'b0, b_req_uns = 1'b0, b_rsp_ready = 1'b0;
    logic [1:0]  b_req_size = 2'd0;
    logic [31:0] b_req_addr = 32'd0;
    logic [63:0] b_req_wdata = 64'd0;
    logic        b_mem_ready = 1'b0, b_mem_rvalid = 1'b0;
    logic [63:0] b_mem_rdata = 64'd0;
    logic        b_req_ready, b_rsp_valid, b_rsp_trap, b_rsp_timeout, b_mem_valid, b_mem_ren, b_mem_wen;
    logic [63:0] b_rsp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_mask;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_trap(rsp_trap), .o_rsp_timeout(rsp_timeout),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata),
        .o_mem_mask(mem_mask), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    lsu_mem_port #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_wen(b_req_wen),
        .i_req_size(b_req_size), .i_req_unsigned(b_req_uns), .i_req_addr(b_req_addr),
        .i_req_wdata(b_req_wdata), .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
        .o_rsp_rdata(b_rsp_rdata), .o_rsp_trap(b_rsp_trap), .o_rsp_timeout(b_rsp_timeout),
        .o_mem_valid(b_mem_valid), .i_mem_ready(b_mem_ready), .o_mem_addr(b_mem_addr),
        .o_mem_ren(b_mem_ren), .o_mem_wen(b_mem_wen), .o_mem_wdata(b_mem_wdata),
        .o_mem_mask(b_mem_mask), .i_mem_rvalid(b_mem_rvalid), .i_mem_rdata(b_mem_rdata)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if ({rsp_valid, rsp_trap, rsp_timeout, mem_valid, mem_ren, mem_wen} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {rsp_valid, rsp_trap, rsp_timeout, mem_valid, mem_ren, mem_wen}); end
        n_checks++; if ({rsp_rdata, mem_addr, mem_wdata, mem_mask} !== 100'd0) begin n_fail++; $display("FAIL reset_buses: got %h expected 0", {rsp_rdata, mem_addr, mem_wdata, mem_mask}); end
        n_checks++; if (b_req_ready !== 1'b1 || b_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dut64: got ready=%b mem_valid=%b expected 1/0", b_req_ready, b_mem_valid); end
    endtask

    task automatic test_load_byte();
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_addr = 32'h0000_1003;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8012_3456;
        tick(); req_valid = 1'b0;
        n_checks++; if ({mem_valid, mem_ren, mem_wen} !== 3'b110) begin n_fail++; $display("FAIL lb_strobes: got %b expected 110", {mem_valid, mem_ren, mem_wen}); end
        n_checks++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_addr: got %h expected 00001000", mem_addr); end
        n_checks++; if (mem_mask !== 4'b1000) begin n_fail++; $display("FAIL lb_mask: got %b expected 1000", mem_mask); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wait: got rsp_valid=%b mem_valid=%b expected 0/0", rsp_valid, mem_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lb_latency: got rsp_valid=%b expected 1", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", rsp_rdata); end
        mem_ready = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lb_release: got ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_store_half();
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd1; req_addr = 32'h0000_2002; req_wdata = 32'h0000_BEEF;
        tick(); req_valid = 1'b0; req_wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({mem_valid, mem_wen, mem_ren} !== 3'b110 || mem_wdata !== 32'hBEEF_0000 || mem_mask !== 4'b1100) begin
                n_fail++; $display("FAIL sh_req_hold%0d: got v/w/r=%b wdata=%h mask=%b expected 110 beef0000 1100", i, {mem_valid, mem_wen, mem_ren}, mem_wdata, mem_mask);
            end
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL sh_rsp: got valid=%b rdata=%h mem_valid=%b expected 1 0 0", rsp_valid, rsp_rdata, mem_valid); end
        // Hold the response for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_trap !== 1'b0 || rsp_rdata !== 32'd0) begin
                n_fail++; $display("FAIL resp_hold%0d: got valid=%b ready=%b trap=%b rdata=%h expected 1 0 0 0", i, rsp_valid, req_ready, rsp_trap, rsp_rdata);
            end
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_trap();
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h0000_3001;
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_trap !== 1'b1 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL lw_trap: got valid=%b trap=%b mem_valid=%b expected 1 1 0", rsp_valid, rsp_trap, mem_valid); end
        // Next request presented while the response is consumed: not accepted that cycle.
        req_size = 2'd3; req_addr = 32'h0000_3000; rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL trap_no_overlap: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
        tick(); req_valid = 1'b0;
        n_checks++; if (rsp_trap !== 1'b1 || rsp_valid !== 1'b1 || mem_valid !== 1'b0 || rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL size3_trap: got trap=%b valid=%b mem_valid=%b rdata=%h expected 1 1 0 0", rsp_trap, rsp_valid, mem_valid, rsp_rdata); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h0000_5000;
        tick(); req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (mem_valid !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_req%0d: got mem_valid=%b rsp_valid=%b expected 1 0", i, mem_valid, rsp_valid); end
            tick();
        end
        // Eighth REQ cycle: a ready arriving now is ignored.
        n_checks++; if (mem_valid !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_req_last: got mem_valid=%b rsp_valid=%b expected 1 0", mem_valid, rsp_valid); end
        mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_trap !== 1'b0 || rsp_rdata !== 32'd0 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_rsp: got valid=%b timeout=%b trap=%b rdata=%h mem_valid=%b expected 1 1 0 0 0", rsp_valid, rsp_timeout, rsp_trap, rsp_rdata, mem_valid);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick(); mem_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL to_late_rvalid: got valid=%b ready=%b timeout=%b expected 0 1 0", rsp_valid, req_ready, rsp_timeout); end
        req_valid = 1'b1; req_size = 2'd0; req_uns = 1'b1; req_addr = 32'h0000_6001;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_A500;
        tick(); req_valid = 1'b0;
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00A5 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL lbu_after_to: got valid=%b rdata=%h timeout=%b expected 1 000000a5 0", rsp_valid, rsp_rdata, rsp_timeout); end
        mem_ready = 1'b0; mem_rvalid = 1'b0; req_uns = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_dword64();
        b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_size = 2'd2; b_req_uns = 1'b1; b_req_addr = 32'h0000_4004;
        b_mem_ready = 1'b1; b_mem_rvalid = 1'b1; b_mem_rdata = 64'h89AB_CDEF_7654_3210;
        tick(); b_req_valid = 1'b0;
        n_checks++; if (b_mem_mask !== 8'hF0 || b_mem_addr !== 32'h0000_4000) begin n_fail++; $display("FAIL lwu64_req: got mask=%h addr=%h expected f0 00004000", b_mem_mask, b_mem_addr); end
        tick(); tick();
        n_checks++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'h0000_0000_89AB_CDEF) begin n_fail++; $display("FAIL lwu64_rdata: got valid=%b rdata=%h expected 1 0000000089abcdef", b_rsp_valid, b_rsp_rdata); end
        b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0;
        b_req_valid = 1'b1; b_req_uns = 1'b0;
        tick(); b_req_valid = 1'b0; tick(); tick();
        n_checks++; if (b_rsp_rdata !== 64'hFFFF_FFFF_89AB_CDEF) begin n_fail++; $display("FAIL lw64_rdata: got %h expected ffffffff89abcdef", b_rsp_rdata); end
        b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0;
        // Byte store into lane 5
        b_mem_rvalid = 1'b0; b_mem_ready = 1'b0;
        b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_size = 2'd0; b_req_addr = 32'h0000_4005; b_req_wdata = 64'h0000_0000_0000_00AB;
        tick(); b_req_valid = 1'b0;
        n_checks++; if (b_mem_wdata !== 64'h0000_AB00_0000_0000 || b_mem_mask !== 8'h20 || b_mem_wen !== 1'b1 || b_mem_ren !== 1'b0) begin
            n_fail++; $display("FAIL sb64_req: got wdata=%h mask=%h wen=%b ren=%b expected 0000ab0000000000 20 1 0", b_mem_wdata, b_mem_mask, b_mem_wen, b_mem_ren);
        end
        b_mem_ready = 1'b1; tick(); b_mem_ready = 1'b0;
        n_checks++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL sb64_rsp: got valid=%b rdata=%h expected 1 0", b_rsp_valid, b_rsp_rdata); end
        b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0; b_req_wen = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h0000_7000; mem_ready = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); mem_ready = 1'b0;
        n_checks++; if (mem_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait: got mem_valid=%b rsp_valid=%b ready=%b expected 0 0 0", mem_valid, rsp_valid, req_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || {rsp_valid, rsp_trap, rsp_timeout, mem_valid, mem_ren, mem_wen} !== 6'b0 || rsp_rdata !== 32'd0 || mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid: got ready=%b flags=%b rdata=%h addr=%h expected 1 000000 0 0", req_ready, {rsp_valid, rsp_trap, rsp_timeout, mem_valid, mem_ren, mem_wen}, rsp_rdata, mem_addr);
        end
        tick(); rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick(); tick(); mem_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_late_rvalid: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_load_byte();
        test_store_half();
        test_trap();
        test_timeout();
        test_dword64();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
